stage_req_sequencer: RTL
========================

# stage_req_sequencer

Clocked, parametrised successor to the per-opcode stage request controller. It accepts an instruction start pulse with its RV32I opcode and decodes which pipeline stages the instruction needs. It then issues one-hot stage requests in order, each held until that stage acknowledges. It sits between instruction issue and the datapath stage units, and reports completion, illegal opcodes and acknowledge timeouts.

## Interface
- NUM_STAGES, 4, number of sequenced stages (≥4); stage 0 first, stage NUM_STAGES-1 is write-back
- MEM_STAGE, NUM_STAGES-2, index of the memory stage (skipped by non-memory opcodes)
- DUAL_STAGE, 1, index of the stage with two parallel sub-requests (req plus req_dual)
- TIMEOUT, 255, max cycles a request waits for ack; 0 disables timeout
- CNT_W, 8, timeout counter width; TIMEOUT < 2^CNT_W
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- set  in  1  start pulse, sampled in IDLE only
- opcode  in  7  RV32I opcode, sampled with set
- ack  in  NUM_STAGES  per-stage acknowledge
- ack_dual  in  1  acknowledge of the second sub-request of DUAL_STAGE
- req  out  NUM_STAGES  one-hot stage request, registered
- req_dual  out  1  second sub-request of DUAL_STAGE, registered
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse, all required stages acknowledged
- illegal  out  1  one-cycle pulse, unsupported opcode at set
- timeout  out  1  one-cycle pulse, sequence aborted on ack timeout

## Operation
- Stage mask decoded from opcode at set:
  - 0000011 load: all stages
  - 0100011 store: all except write-back
  - 1100011 branch: all except MEM_STAGE and write-back
  - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111: all except MEM_STAGE
  - anything else: illegal
- FSM states: IDLE, REQ.
- IDLE → REQ on set=1 with legal opcode. Latch mask, cur=0, busy=1, req[0]=1. Stage 0 is always in every mask.
- On set=1 with illegal opcode: illegal=1 for one cycle, remain IDLE, no req.
- REQ: req[cur] held high until its ack is sampled high.
  - For cur==DUAL_STAGE, req_dual is raised together with req[cur].
  - ack[cur] and ack_dual are each latched when seen; the stage completes when both are latched, in the same or different cycles.
  - Each sub-request drops the cycle after its own ack.
- Stage completion: on the same edge, req[cur] clears and the next enabled stage's req sets (no gap). Skipped stages never see req.
- After the last enabled stage completes: done=1 for one cycle, busy=0, req=0, → IDLE.
- Ignored inputs:
  - ack bits of non-current stages, and any ack in IDLE
  - set while busy
  - ack_dual outside DUAL_STAGE
- Timeout (TIMEOUT>0):
  - Counter clears whenever a new stage request starts and increments each REQ cycle without completion.
  - When it reaches TIMEOUT, at that edge: req and req_dual clear, timeout=1 for one cycle, busy=0, → IDLE, no done.
- Output invariant: at most one req bit high at any time.

## Timing
- Reset (reset=0, asynchronous): state IDLE; req=0, req_dual=0, busy=0, done=0, illegal=0, timeout=0, counter=0, ack latches cleared. Applies immediately, also mid-sequence; no done or timeout pulse is generated.
- set sampled at edge k → req[0] and busy high after edge k.
- ack[cur] sampled at edge m → req[cur] low and next req high after edge m.
- With acks tied high, an N-stage instruction occupies exactly N cycles of req.
- done follows the final ack by one edge. busy falls on the same edge; a new set is accepted on the following edge.
- illegal is asserted after the edge sampling set; busy stays 0.
- Timeout fires exactly TIMEOUT cycles after req rises without completion.

## Test plan
- Load 0000011, NUM_STAGES=4, all acks tied high:
  - req sequence is 0001, 0010, 0100, 1000 on consecutive cycles
  - req_dual high with 0010
  - done on the 5th edge after set
- R-type 0110011, ack returned 2 cycles after each req:
  - req goes 0001, 0010, 1000
  - req[2] never asserts
  - done once
- Branch 1100011, ack[1] at cycle 3 and ack_dual at cycle 6 after stage 1 starts:
  - req[1] drops after cycle 3
  - req_dual drops after cycle 6
  - req[3] never asserts
  - done after stage 0 completes and the stage-1 join
- Opcode 1111111 with set:
  - illegal pulses once
  - busy, req and done stay 0
- TIMEOUT=4, store 0100011, ack[2] never returned:
  - req[2] high 4 cycles, then clears
  - timeout pulses, no done
  - next set accepted
- reset=0 asynchronously during stage 1 of a load: all outputs 0 immediately; after release, a new set starts cleanly at req=0001.

Source files
------------

// File: rtl/stage_req_sequencer.sv
// stage_req_sequencer: decodes an RV32I opcode into a stage mask and issues
// one-hot stage requests in order. Each request is held until its stage
// acknowledges. The sequencer reports completion, illegal opcodes and
// acknowledge timeouts.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   set       start pulse, sampled in IDLE only
//   opcode    RV32I opcode, sampled with set
//   ack       per-stage acknowledge
//   ack_dual  acknowledge of the second sub-request of DUAL_STAGE
//   req       one-hot stage request (registered)
//   req_dual  second sub-request of DUAL_STAGE (registered)
//   busy      sequence in progress
//   done      one-cycle pulse, all required stages acknowledged
//   illegal   one-cycle pulse, unsupported opcode at set
//   timeout   one-cycle pulse, sequence aborted on ack timeout
module stage_req_sequencer #(
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned MEM_STAGE  = NUM_STAGES - 2,
   parameter int unsigned DUAL_STAGE = 1,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set,
   input  logic [6:0]            opcode,
   input  logic [NUM_STAGES-1:0] ack,
   input  logic                  ack_dual,
   output logic [NUM_STAGES-1:0] req,
   output logic                  req_dual,
   output logic                  busy,
   output logic                  done,
   output logic                  illegal,
   output logic                  timeout
);

   localparam int unsigned IDX_W    = $clog2(NUM_STAGES);
   localparam int unsigned WB_STAGE = NUM_STAGES - 1;

   localparam logic [NUM_STAGES-1:0] BIT_WB      = NUM_STAGES'(1) << WB_STAGE;
   localparam logic [NUM_STAGES-1:0] BIT_MEM     = NUM_STAGES'(1) << MEM_STAGE;
   localparam logic [NUM_STAGES-1:0] MASK_ALL    = '1;
   localparam logic [NUM_STAGES-1:0] MASK_STORE  = MASK_ALL & ~BIT_WB;
   localparam logic [NUM_STAGES-1:0] MASK_BRANCH = MASK_ALL & ~BIT_WB & ~BIT_MEM;
   localparam logic [NUM_STAGES-1:0] MASK_ALU    = MASK_ALL & ~BIT_MEM;
   localparam logic                  TO_EN       = (TIMEOUT != 0);
   localparam logic                  DUAL_FIRST  = (DUAL_STAGE == 0);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_STAGES-1:0] mask_q, mask_d;
   logic [IDX_W-1:0]      cur_q, cur_d;
   logic                  ack_seen_q, ack_seen_d;
   logic                  dual_seen_q, dual_seen_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_STAGES-1:0] req_d;
   logic                  req_dual_d, busy_d, done_d, illegal_d, timeout_d;

   logic                  dec_legal;
   logic [NUM_STAGES-1:0] dec_mask;
   logic                  nxt_found;
   logic [IDX_W-1:0]      nxt_idx;
   logic                  is_dual, ack_hit, dual_hit, complete, to_hit;
   logic [CNT_W-1:0]      cnt_inc;

   // Opcode to required-stage mask.
   always_comb begin
      dec_legal = 1'b1;
      dec_mask  = '0;
      case (opcode)
         7'b0000011: dec_mask = MASK_ALL;
         7'b0100011: dec_mask = MASK_STORE;
         7'b1100011: dec_mask = MASK_BRANCH;
         7'b0110011, 7'b0010011, 7'b0110111,
         7'b0010111, 7'b1101111, 7'b1100111: dec_mask = MASK_ALU;
         default: dec_legal = 1'b0;
      endcase
   end

   // Lowest enabled stage above the current one; scanning downward lets the
   // smallest index win.
   always_comb begin
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(cur_q))) begin
            nxt_found = 1'b1;
            nxt_idx   = IDX_W'(i);
         end
      end
   end

   // Join of the current stage: both sub-acks may arrive in any order.
   always_comb begin
      is_dual  = (cur_q == IDX_W'(DUAL_STAGE));
      ack_hit  = ack_seen_q | ack[cur_q];
      dual_hit = is_dual ? (dual_seen_q | ack_dual) : 1'b1;
      complete = ack_hit & dual_hit;
      cnt_inc  = cnt_q + CNT_W'(1);
      to_hit   = TO_EN & (cnt_inc == CNT_W'(TIMEOUT));
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      cur_d       = cur_q;
      ack_seen_d  = ack_seen_q;
      dual_seen_d = dual_seen_q;
      cnt_d       = cnt_q;
      req_d       = req;
      req_dual_d  = req_dual;
      busy_d      = busy;
      done_d      = 1'b0;
      illegal_d   = 1'b0;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            req_d      = '0;
            req_dual_d = 1'b0;
            busy_d     = 1'b0;
            if (set) begin
               if (dec_legal) begin
                  state_d     = REQ;
                  mask_d      = dec_mask | NUM_STAGES'(1);
                  cur_d       = '0;
                  ack_seen_d  = 1'b0;
                  dual_seen_d = 1'b0;
                  cnt_d       = '0;
                  req_d       = NUM_STAGES'(1);
                  req_dual_d  = DUAL_FIRST;
                  busy_d      = 1'b1;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end

         REQ: begin
            if (complete) begin
               ack_seen_d  = 1'b0;
               dual_seen_d = 1'b0;
               cnt_d       = '0;
               if (nxt_found) begin
                  cur_d      = nxt_idx;
                  req_d      = NUM_STAGES'(1) << nxt_idx;
                  req_dual_d = (nxt_idx == IDX_W'(DUAL_STAGE));
               end else begin
                  state_d    = IDLE;
                  req_d      = '0;
                  req_dual_d = 1'b0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
               end
            end else if (to_hit) begin
               state_d     = IDLE;
               ack_seen_d  = 1'b0;
               dual_seen_d = 1'b0;
               cnt_d       = '0;
               req_d       = '0;
               req_dual_d  = 1'b0;
               busy_d      = 1'b0;
               timeout_d   = 1'b1;
            end else begin
               // Each sub-request drops the cycle after its own ack.
               ack_seen_d  = ack_hit;
               dual_seen_d = is_dual & dual_hit;
               req_d       = ack_hit ? '0 : (NUM_STAGES'(1) << cur_q);
               req_dual_d  = is_dual & ~(dual_seen_q | ack_dual);
               cnt_d       = TO_EN ? cnt_inc : cnt_q;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mask_q      <= '0;
         cur_q       <= '0;
         ack_seen_q  <= 1'b0;
         dual_seen_q <= 1'b0;
         cnt_q       <= '0;
         req         <= '0;
         req_dual    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         cur_q       <= cur_d;
         ack_seen_q  <= ack_seen_d;
         dual_seen_q <= dual_seen_d;
         cnt_q       <= cnt_d;
         req         <= req_d;
         req_dual    <= req_dual_d;
         busy        <= busy_d;
         done        <= done_d;
         illegal     <= illegal_d;
         timeout     <= timeout_d;
      end
   end

endmodule
